// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end: PC, one-cycle fetch tracking, skid FIFO to decode
// Credit-based issue keeps buffered plus in-flight words within SKID_DEPTH.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          SKID_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPC,
  output logic [31:0] o_instrAddr,
  output logic        o_enIF,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);
  localparam int PW  = $clog2(SKID_DEPTH);
  localparam int CW  = $clog2(SKID_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);
  localparam logic [CW:0]   CREDIT   = CW1'(SKID_DEPTH - 1);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc    [SKID_DEPTH];
  logic [31:0]   fifo_instr [SKID_DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign unused_redirect_lsbs = ^i_redirectPC[1:0];

  assign o_valid     = (count != '0);
  assign pop         = o_valid & i_ready & ~i_redirect;
  // A response landing in a redirect cycle is dropped along with the flush.
  assign push        = inflight & ~kill & ~i_redirect;
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue       = ~i_reset & ~i_redirect & (occupancy <= CREDIT + {{CW{1'b0}}, pop});
  assign o_enIF      = issue;
  assign o_instrAddr = {pc[31:2], 2'b00};
  assign o_instr     = o_valid ? fifo_instr[rd_ptr] : '0;
  assign o_pc        = o_valid ? fifo_pc[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= issue;
      kill     <= i_redirect & inflight;
      if (issue) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
      if (i_redirect) begin
        pc     <= {i_redirectPC[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= i_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized bench for if_fetch_unit
// Reference: expected next delivered PC, word = (addr>>2)*0x11, issued-minus-consumed bound.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          SKID_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_addr;
  logic        en_if;
  logic [31:0] mem_data = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .SKID_DEPTH(SKID_DEPTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_redirect(redirect), .i_redirectPC(redirect_pc),
    .o_instrAddr(instr_addr), .o_enIF(en_if), .i_instr(mem_data),
    .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h11;
  endfunction

  always #5 clk = ~clk;

  // Memory port: word latched at an enabled edge, garbage otherwise.
  always @(posedge clk) mem_data <= en_if ? mem_word(instr_addr) : $urandom;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ready = 1'b1; redirect = 1'b0;
    next_cycle(); next_cycle();
    #1;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid);
    if (valid !== 1'b0) errors++;
    checks++; if (en_if !== 1'b0) begin errors++; $display("FAIL reset_enif: got %0b want 0", en_if); end
    checks++; if (pc !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: pc=%h instr=%h want 0/0", pc, instr);
    end
    reset = 1'b0;
    exp_pc = RESET_PC;
    for (int c = 1; c <= 8; c++) begin
      #1;
      checks++; if (en_if !== 1'b1) begin errors++; $display("FAIL start_enif c%0d: got %0b want 1", c, en_if); end
      checks++; if (valid !== (c >= 3)) begin errors++; $display("FAIL start_valid c%0d: got %0b want %0b", c, valid, c >= 3); end
      if (c == 1) begin
        checks++; if (instr_addr !== RESET_PC) begin errors++; $display("FAIL start_addr: got %h want %h", instr_addr, RESET_PC); end
      end
      if (c >= 3) begin
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL start_data c%0d: pc=%h instr=%h want %h/%h", c, pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      ready = 1'b0; #1;
      if (k >= 1) begin
        checks++; if (en_if !== 1'b0) begin errors++; $display("FAIL stall_enif k%0d: got %0b want 0", k, en_if); end
      end
      checks++;
      if (valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        errors++; $display("FAIL stall_hold k%0d: v=%0b pc=%h instr=%h want 1/%h/%h", k, valid, pc, instr, exp_pc, mem_word(exp_pc));
      end
      next_cycle();
    end
    for (int k = 0; k < 6; k++) begin
      ready = 1'b1; #1;
      checks++;
      if (valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        errors++; $display("FAIL stall_resume k%0d: v=%0b pc=%h instr=%h want 1/%h/%h", k, valid, pc, instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 4;
      next_cycle();
    end
  endtask

  // Issues one redirect (optionally preceded by a stall to fill the FIFO) then follows the restart.
  task automatic redirect_run(input string name, input logic [31:0] target, input int stall_cycles);
    for (int k = 0; k < stall_cycles; k++) begin
      ready = 1'b0; next_cycle();
    end
    ready = 1'b1; redirect = 1'b1; redirect_pc = target; #1;
    checks++; if (en_if !== 1'b0) begin errors++; $display("FAIL %s_enif_r: got %0b want 0", name, en_if); end
    next_cycle();
    redirect = 1'b0;
    exp_pc = target & ~32'h3;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c == 1) begin
        checks++; if (instr_addr !== exp_pc || en_if !== 1'b1) begin
          errors++; $display("FAIL %s_addr: addr=%h en=%0b want %h/1", name, instr_addr, en_if, exp_pc);
        end
      end
      if (c < 3) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s_flush c%0d: valid=%0b want 0", name, c, valid); end
      end else begin
        checks++;
        if (valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL %s_data c%0d: v=%0b pc=%h instr=%h want 1/%h/%h", name, c, valid, pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    redirect_run("redir_inflight", 32'h0000_0100, 0);
    redirect_run("redir_full_unaligned", 32'h0000_0203, 3);
  endtask

  task automatic test_back_to_back();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    next_cycle();
    redirect_pc = 32'h80; #1;
    checks++; if (valid !== 1'b0 || en_if !== 1'b0) begin
      errors++; $display("FAIL b2b_second: valid=%0b en=%0b want 0/0", valid, en_if);
    end
    next_cycle();
    redirect = 1'b0;
    exp_pc = 32'h80;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c == 1) begin
        checks++; if (instr_addr !== 32'h80) begin errors++; $display("FAIL b2b_addr: got %h want 00000080", instr_addr); end
      end
      if (c < 3) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_flush c%0d: valid=%0b want 0", c, valid); end
      end else begin
        checks++;
        if (valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL b2b_data c%0d: v=%0b pc=%h want 1/%h", c, valid, pc, exp_pc);
        end
        exp_pc += 4;
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    redirect_run("wrap", 32'hFFFF_FFF8, 0);
    checks++; if (exp_pc !== 32'h0000_0008) begin
      errors++; $display("FAIL wrap_model: exp=%h want 00000008", exp_pc);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      ready = 1'b0; next_cycle();
    end
    reset = 1'b1; #1;
    checks++; if (en_if !== 1'b0) begin errors++; $display("FAIL rstmid_enif_r: got %0b want 0", en_if); end
    next_cycle();
    reset = 1'b0; ready = 1'b1;
    exp_pc = RESET_PC;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c == 1) begin
        checks++; if (en_if !== 1'b1 || instr_addr !== RESET_PC) begin
          errors++; $display("FAIL rstmid_restart: en=%0b addr=%h want 1/%h", en_if, instr_addr, RESET_PC);
        end
      end
      if (c < 3) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty c%0d: valid=%0b want 0", c, valid); end
      end else begin
        checks++;
        if (valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rstmid_data c%0d: v=%0b pc=%h want 1/%h", c, valid, pc, exp_pc);
        end
        exp_pc += 4;
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int          outstanding = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;
    for (int i = 0; i < 400; i++) begin
      ready       = ($urandom_range(0, 9) < 7);
      redirect    = (i == 0) || ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom & 32'h0000_FFFF;
      #1;
      if (!valid) begin
        checks++; if (pc !== 32'h0 || instr !== 32'h0) begin
          errors++; $display("FAIL rnd_idle i%0d: pc=%h instr=%h want 0/0", i, pc, instr);
        end
      end
      if (prev_hold) begin
        checks++; if (valid !== 1'b1 || pc !== prev_pc) begin
          errors++; $display("FAIL rnd_stable i%0d: v=%0b pc=%h want 1/%h", i, valid, pc, prev_pc);
        end
      end
      if (redirect) begin
        checks++; if (en_if !== 1'b0) begin errors++; $display("FAIL rnd_redir_enif i%0d: got %0b want 0", i, en_if); end
      end
      if (valid && ready && !redirect) begin
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rnd_data i%0d: pc=%h instr=%h want %h/%h", i, pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
        outstanding--;
      end
      if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
        outstanding = 0;
      end
      if (en_if) outstanding++;
      checks++; if (outstanding > SKID_DEPTH) begin
        errors++; $display("FAIL rnd_occupancy i%0d: got %0d want <= %0d", i, outstanding, SKID_DEPTH);
      end
      prev_hold = valid && !ready && !redirect;
      prev_pc   = pc;
      next_cycle();
    end
    redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
